fib_seq_ctrl: RTL and testbench

//   Start/done sequencer that computes Fib(n) iteratively over an a/b register pair.
//   It holds the registered a/b state for the Fibonacci datapath and steps it one

---
 rtl/fib_seq_ctrl.sv | 112 +++++++++++
 tb/tb_fib_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: start/done sequencer computing Fib(n) iteratively.
//
// An a/b register pair walks the Fibonacci sequence one addition per clock:
// a holds Fib(k) and b holds Fib(k+1) after k steps. A down-counter loaded
// with the requested index decides when to stop. The value in a is then
// delivered as the result.
//
// Overflow is tracked per value rather than per addition. b always runs one
// term ahead of a, so b can wrap while a still fits. Each register carries
// its own sticky "has wrapped" flag, and that flag travels with the value
// when b is copied into a. The reported ovf is the flag attached to a.
//
// Handshake: start is a level request that is looked at only in IDLE. The
// cycle in which the FSM is in IDLE with start==1 is the accepting cycle, and
// n is captured on that same edge. start or n activity while busy (CALC) or
// in DONE is ignored and not queued. done is a single-cycle pulse during
// which result/ovf are already valid, and both stay held until the next
// accepted start.
//
// The FSM state is visible on fsm_state (0=IDLE, 1=CALC, 2=DONE) so external
// checkers can follow the sequencing.

module fib_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int NW    = 5
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             start,
    input  logic [NW-1:0]    n,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_ovf;     // a holds a value whose true magnitude wrapped
    logic             b_ovf;     // b holds a value whose true magnitude wrapped
    logic [NW-1:0]    cnt;       // additions still to perform
    logic [WIDTH:0]   sum;       // a+b with the carry bit kept

    // Full-width sum so the carry out of the addition can be observed.
    assign sum = {1'b0, a} + {1'b0, b};

    // Sequencer and datapath: reset first, then one FSM transition per edge.
    always_ff @(posedge clk) begin
        if (!CLR) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        b     <= {{(WIDTH-1){1'b0}}, 1'b1};
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                        cnt   <= n;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        // New b is the sum; it is flagged if either operand was
                        // already wrapped or this addition carried out.
                        a     <= b;
                        b     <= sum[WIDTH-1:0];
                        a_ovf <= b_ovf;
                        b_ovf <= a_ovf | b_ovf | sum[WIDTH];
                        cnt   <= cnt - NW'(1);
                    end else begin
                        result <= a;
                        ovf    <= a_ovf;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status strobes decoded straight from state (and cnt for the load strobe).
    always_comb begin
        busy      = (state == CALC);
        step      = (state == CALC) && (cnt != '0);
        done      = (state == DONE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: table-driven and scoreboard-based bench for fib_seq_ctrl.

module tb_fib_seq_ctrl;

    localparam int W   = 16;
    localparam int NWD = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic CLR = 1'b0;
    always #5 clk = ~clk;

    // 16-bit DUT
    logic           start = 1'b0;
    logic [NWD-1:0] n     = '0;
    logic           busy, step, done, ovf;
    logic [W-1:0]   result;
    logic [1:0]     fsm_state;

    // 32-bit DUT for the wide-result case
    logic           start32 = 1'b0;
    logic [NWD-1:0] n32     = '0;
    logic           busy32, step32, done32, ovf32;
    logic [31:0]    result32;
    logic [1:0]     fsm_state32;

    fib_seq_ctrl #(.WIDTH(W), .NW(NWD)) dut (
        .clk(clk), .CLR(CLR), .start(start), .n(n),
        .busy(busy), .step(step), .done(done),
        .result(result), .ovf(ovf), .fsm_state(fsm_state)
    );

    fib_seq_ctrl #(.WIDTH(32), .NW(NWD)) dut32 (
        .clk(clk), .CLR(CLR), .start(start32), .n(n32),
        .busy(busy32), .step(step32), .done(done32),
        .result(result32), .ovf(ovf32), .fsm_state(fsm_state32)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [W:0] exp_q[$];   // {ovf, result}

    typedef struct {
        int         n;
        logic [W-1:0] res;
        logic       ovf;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: iterate Fibonacci in 64 bits, report value mod 2**W and overflow.
    function automatic logic [W:0] model(input int k);
        logic [63:0] x, y, t;
        x = 64'd0;
        y = 64'd1;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return {((x >> W) != 64'd0), x[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Request Fib(nn) and push the expectation; returns at the negedge after E0.
    task automatic launch(input int nn, input logic [W:0] exp);
        @(negedge clk);
        start = 1'b1;
        n     = NWD'(nn);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n     = NWD'($urandom_range(0, 31));   // must not matter after acceptance
    endtask

    // Wait for done, counting edges and step pulses; optionally poke start
    // (n=3) for one cycle at edge count poke_at.
    task automatic wait_done(input int nn, input int poke_at, input string tag);
        int   edges;
        int   steps;
        bit   got;
        logic [W:0] e;
        edges = 0;
        steps = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            if (step) steps++;
            if (edges == poke_at) begin
                start = 1'b1;
                n     = NWD'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(edges), 64'(nn + 1));
            check({tag, "_steps"}, 64'(steps), 64'(nn));
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_result"}, 64'(result), 64'(e[W-1:0]));
                check({tag, "_ovf"}, 64'(ovf), 64'(e[W]));
            end
            @(negedge clk);
            check({tag, "_done_1cyc"}, 64'(done), 64'd0);
            check({tag, "_idle"}, 64'(fsm_state), 64'd0);
            if (exp_q.size() == 0 && got)
                check({tag, "_held"}, 64'(result), 64'(e[W-1:0]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        int dcount;
        int edges32;

        vecs[0] = '{n: 0,  res: 16'd0,     ovf: 1'b0};
        vecs[1] = '{n: 1,  res: 16'd1,     ovf: 1'b0};
        vecs[2] = '{n: 10, res: 16'd55,    ovf: 1'b0};
        vecs[3] = '{n: 24, res: 16'd46368, ovf: 1'b0};
        vecs[4] = '{n: 25, res: 16'd9489,  ovf: 1'b1};
        vecs[5] = '{n: 31, res: 16'd35549, ovf: 1'b1};
        vecs[6] = '{n: 2,  res: 16'd1,     ovf: 1'b0};
        vecs[7] = '{n: 20, res: 16'd6765,  ovf: 1'b0};

        // Reset held for two edges, then idle with no start.
        CLR = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_result", 64'(result), 64'd0);
            check("rst_ovf", 64'(ovf), 64'd0);
        end
        check("rst_step", 64'(step), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].n, {vecs[i].ovf, vecs[i].res});
            wait_done(vecs[i].n, -1, $sformatf("vec%0d_n%0d", i, vecs[i].n));
        end

        // start while busy is ignored.
        launch(20, {1'b0, 16'd6765});
        wait_done(20, 5, "ignore_n20");
        launch(3, {1'b0, 16'd2});
        wait_done(3, -1, "after_ignore_n3");

        // Reset in the middle of a computation abandons it.
        @(negedge clk);
        start = 1'b1;
        n     = NWD'(15);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        CLR = 1'b0;
        @(posedge clk);
        @(negedge clk);
        CLR = 1'b1;
        check("midrst_state", 64'(fsm_state), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 64'(dcount), 64'd0);
        launch(5, {1'b0, 16'd5});
        wait_done(5, -1, "midrst_then_n5");

        // Random indices against the bench model.
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(0, 31);
            launch(k, model(k));
            wait_done(k, -1, $sformatf("rand%0d_n%0d", i, k));
        end

        // 32-bit instance: Fib(31) fits, no overflow.
        @(negedge clk);
        start32 = 1'b1;
        n32     = NWD'(31);
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        edges32 = 0;
        while (!done32 && edges32 < 100) begin
            @(posedge clk);
            edges32++;
            @(negedge clk);
        end
        check("w32_latency", 64'(edges32), 64'd32);
        check("w32_result", 64'(result32), 64'd1346269);
        check("w32_ovf", 64'(ovf32), 64'd0);
        @(negedge clk);
        check("w32_idle", 64'(fsm_state32), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
